ltl_violation_collector: RTL
============================

// Module: ltl_violation_collector
// PURPOSE
//  Downstream consumer of the cluster-0 LTL monitor. Takes the 11 per-property violation flags
//  (ltl0c0..ltl10c0), rising-edge detects each one and timestamps it with a free-running cycle count.
//  Events are serialised into a small FIFO and drained over a valid/ready port to the trace/CSR side.
//  Also keeps sticky per-property status, an overflow flag and a level interrupt.
// PARAMETERS
//  NUM_PROPS   11  number of property flags; bit i = ltl<i>c0
//  TS_W        32  timestamp / cycle counter width
//  FIFO_DEPTH  4   event FIFO entries; power of 2, >=2
// PORTS
//  clk            in   1          clock
//  reset          in   1          asynchronous, active-low reset
//  run            in   1          monitor enable; same signal that drives the cluster top
//  ltl_flags      in   NUM_PROPS  {ltl10c0,...,ltl0c0}
//  clear_sticky   in   1          1-cycle pulse; clears sticky_status and overflow
//  evt_valid      out  1          event available
//  evt_ready      in   1          consumer accepts when evt_valid&evt_ready
//  evt_prop_id    out  4          index of violated property ($clog2(NUM_PROPS))
//  evt_timestamp  out  TS_W       cycle count latched at the rising edge
//  sticky_status  out  NUM_PROPS  bit i set on any ltl<i> rising edge
//  overflow       out  1          sticky; an edge was lost (prop already pending)
//  irq            out  1          |sticky_status | overflow
// BEHAVIOUR
//  Reset (reset==0, async): all outputs 0, cycle counter 0, prev_flags 0, pending 0, FIFO empty.
//  Counter: +1 per clk while run=1, wraps 2^TS_W-1 -> 0, holds while run=0.
//  Edge detect (only while run=1): rise[i] = ltl_flags[i] & ~prev_flags[i]; prev_flags <= ltl_flags.
//   While run=0, prev_flags and pending are not updated and no new events are raised.
//  On rise[i]: if pending[i]==0, set pending[i] and latch ts[i] <= current counter (pre-increment).
//   If pending[i]==1, drop the edge and set overflow. Sticky bit i is set in either case.
//  Arbiter: each cycle, if pending!=0 and FIFO not full, push {lowest set index, ts[idx]} and clear
//   pending[idx]. Max one push per cycle. Same-cycle rise on a bit being pushed re-sets pending and
//   re-latches ts (no overflow).
//  Latency: flag rise at cycle N -> evt_valid at N+2 when the FIFO is empty and no lower index is pending.
//  FIFO: full -> no push; pending holds; no loss unless that prop rises again. Empty -> evt_valid=0.
//   Simultaneous push and pop when full is not allowed (push gated on !full, registered).
//   Simultaneous push and pop when empty: push wins, evt_valid=1 next cycle.
//  Handshake: evt_* are driven from the FIFO head. They stay stable while evt_valid&~evt_ready.
//   evt_valid does not drop without acceptance. Draining continues while run=0.
//  Sticky: clear_sticky clears sticky_status and overflow. A same-cycle set has priority over the clear.
//   irq is registered, so it updates 1 cycle after sticky/overflow change.
//  Reset asserted mid-drain: FIFO and pending are discarded immediately. evt_valid=0 asynchronously.
// STRUCTURE
//  ltl_mon_pkg: NUM_PROPS, PROP_ID_W=$clog2(NUM_PROPS), ltl_evt_t {prop_id, timestamp}.
//  Sub-module ltl_evt_fifo: synchronous FIFO of ltl_evt_t with full/empty and valid/ready pop side.
//  Top level holds the counter, edge detect, pending/ts regs, priority arbiter, sticky and irq.
// TESTING
//  1 Reset: hold reset=0, toggle flags -> all outputs 0. Release, run=1, 5 idle cycles -> evt_valid=0, irq=0.
//  2 Single: ltl_flags[3] rises at counter=10, evt_ready=1 -> one event {id=3, ts=10}, 2 cycles later;
//    sticky_status=0x008; irq=1 next cycle.
//  3 Simultaneous: bits 0,5,10 rise at counter=20 -> events in order id 0,5,10, all with ts=20.
//  4 Backpressure: evt_ready=0, 6 distinct props rise -> FIFO holds 4, 2 stay pending, evt_* stable.
//    Release ready -> all 6 drained, overflow=0.
//  5 Overflow: evt_ready=0, FIFO full, prop 7 pending, toggle prop 7 again -> overflow=1.
//    clear_sticky -> overflow=0, sticky=0 unless a set lands in the same cycle.
//  6 run=0: counter frozen, flag rises ignored, queued events still drain. Reset mid-drain -> evt_valid=0 at once.

Source files
------------

// File: rtl/ltl_violation_collector_pkg.sv
// Shared widths and event record for the cluster-0 LTL violation collector.
package ltl_mon_pkg;

    localparam int unsigned NUM_PROPS = 11;
    localparam int unsigned TS_W      = 32;
    localparam int unsigned PROP_ID_W = $clog2(NUM_PROPS);

    typedef struct packed {
        logic [PROP_ID_W-1:0] prop_id;
        logic [TS_W-1:0]      timestamp;
    } ltl_evt_t;

endpackage

// File: rtl/ltl_violation_collector_fifo.sv
// Small synchronous event FIFO; push side gated internally on !full, pop side is valid/ready.
module ltl_evt_fifo
    import ltl_mon_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push,
    input  ltl_evt_t push_data,
    output logic     full,
    output logic     pop_valid,
    input  logic     pop_ready,
    output ltl_evt_t pop_data
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    ltl_evt_t         mem_q [DEPTH];
    ltl_evt_t         mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full      = (count_q == (PTR_W+1)'(DEPTH));
    assign pop_valid = (count_q != '0);
    assign pop_data  = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push & ~full;
        do_pop   = pop_valid & pop_ready;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ltl_violation_collector.sv
// Edge-detects and timestamps LTL violation flags, queues them as events, keeps sticky status and irq.
module ltl_violation_collector
    import ltl_mon_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic [NUM_PROPS-1:0] ltl_flags,
    input  logic                 clear_sticky,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [PROP_ID_W-1:0] evt_prop_id,
    output logic [TS_W-1:0]      evt_timestamp,
    output logic [NUM_PROPS-1:0] sticky_status,
    output logic                 overflow,
    output logic                 irq
);

    logic [TS_W-1:0]      cnt_q, cnt_d;
    logic [NUM_PROPS-1:0] prev_q, prev_d;
    logic [NUM_PROPS-1:0] pend_q, pend_d;
    logic [TS_W-1:0]      ts_q [NUM_PROPS];
    logic [TS_W-1:0]      ts_d [NUM_PROPS];
    logic [NUM_PROPS-1:0] sticky_q, sticky_d;
    logic                 ovf_q, ovf_d;
    logic                 irq_q, irq_d;

    logic [NUM_PROPS-1:0] rise;
    logic [PROP_ID_W-1:0] push_idx;
    logic                 push;
    logic                 ovf_set;
    logic                 fifo_full;
    ltl_evt_t             push_evt;
    ltl_evt_t             head_evt;

    always_comb begin
        cnt_d    = run ? cnt_q + 1'b1 : cnt_q;
        prev_d   = run ? ltl_flags : prev_q;
        pend_d   = pend_q;
        ts_d     = ts_q;
        rise     = run ? (ltl_flags & ~prev_q) : '0;
        push_idx = '0;
        ovf_set  = 1'b0;

        // Descending scan so the lowest pending index is the one left standing.
        for (int unsigned i = NUM_PROPS; i > 0; i--) begin
            if (pend_q[i-1]) begin
                push_idx = PROP_ID_W'(i-1);
            end
        end
        push = (|pend_q) & ~fifo_full;
        push_evt.prop_id   = push_idx;
        push_evt.timestamp = ts_q[push_idx];
        if (push) begin
            pend_d[push_idx] = 1'b0;
        end

        for (int unsigned i = 0; i < NUM_PROPS; i++) begin
            if (rise[i]) begin
                if (pend_d[i]) begin
                    ovf_set = 1'b1;
                end else begin
                    pend_d[i] = 1'b1;
                    ts_d[i]   = cnt_q;
                end
            end
        end

        sticky_d = (clear_sticky ? '0 : sticky_q) | rise;
        ovf_d    = (clear_sticky ? 1'b0 : ovf_q) | ovf_set;
        irq_d    = (|sticky_q) | ovf_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            prev_q   <= '0;
            pend_q   <= '0;
            for (int unsigned i = 0; i < NUM_PROPS; i++) begin
                ts_q[i] <= '0;
            end
            sticky_q <= '0;
            ovf_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            prev_q   <= prev_d;
            pend_q   <= pend_d;
            ts_q     <= ts_d;
            sticky_q <= sticky_d;
            ovf_q    <= ovf_d;
            irq_q    <= irq_d;
        end
    end

    ltl_evt_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_evt),
        .full      (fifo_full),
        .pop_valid (evt_valid),
        .pop_ready (evt_ready),
        .pop_data  (head_evt)
    );

    assign evt_prop_id   = head_evt.prop_id;
    assign evt_timestamp = head_evt.timestamp;
    assign sticky_status = sticky_q;
    assign overflow      = ovf_q;
    assign irq           = irq_q;

endmodule
